// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the load/store unit and its data-memory port.
//   DATA_W : data word width
//   ADDR_W : request and memory address width
//   DEPTH  : number of memory words, valid word addresses are 0..DEPTH-1
//   state_e: LSU controller states
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// -----------------------------------------------------------------------------
// mem_lsu_if
// Bundles the request/response handshake and the data-memory port of the LSU.
//   master : the LSU itself (accepts requests, drives responses and the
//            memory strobes/address/data, receives MEM_RDATA)
//   slave  : the environment (execute stage plus data memory)
// -----------------------------------------------------------------------------
interface mem_lsu_if;
    import mem_pkg::*;

    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WRITE;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;

    logic              RESP_VALID;
    logic              RESP_READY;
    logic [DATA_W-1:0] RESP_RDATA;
    logic              RESP_ERR;

    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic              MEM_WEN;
    logic              MEM_REN;
    logic              WRITE_MF;
    logic [DATA_W-1:0] MEM_RDATA;

    modport master (
        input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, RESP_READY, MEM_RDATA,
        output REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR,
               MEM_ADDR, MEM_WDATA, MEM_WEN, MEM_REN, WRITE_MF
    );

    modport slave (
        output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, RESP_READY, MEM_RDATA,
        input  REQ_READY, RESP_VALID, RESP_RDATA, RESP_ERR,
               MEM_ADDR, MEM_WDATA, MEM_WEN, MEM_REN, WRITE_MF
    );

endinterface

// File: rtl/lsu_sat_counter.sv
// -----------------------------------------------------------------------------
// lsu_sat_counter
// Saturating up-counter used for the completed-transaction count.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low clear
//   inc_en : add one at the next edge unless already all-ones
//   count  : current count
// -----------------------------------------------------------------------------
module lsu_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Holds at all-ones instead of wrapping back to zero.
    always_comb begin
        count_d = count_q;
        if (inc_en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu
// Load/store initiator between the execute stage and a word-addressed data
// memory with 1-cycle registered read latency. One request in flight at a
// time; every request gets exactly one response, held until RESP_READY.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : request/response handshake and memory port (master view)
//   TXN_COUNT : number of completed responses, saturating at all-ones
// Out-of-range addresses (>= DEPTH) are answered with RESP_ERR and never
// strobe the memory.
// -----------------------------------------------------------------------------
module mem_lsu
    import mem_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_lsu_if.master        bus,
    output logic [CNT_W-1:0] TXN_COUNT
);

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              mem_wen_q,    mem_wen_d;
    logic              mem_ren_q,    mem_ren_d;
    logic              write_mf_q,   write_mf_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q,   resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              addr_oob;
    logic              resp_done;

    // Unsigned compare over the full address width.
    assign addr_oob  = (bus.REQ_ADDR >= ADDR_W'(DEPTH));
    assign resp_done = (state_q == RESP) && bus.RESP_READY;

    // Next-state and next-output logic. MEM_ADDR/MEM_WDATA are only loaded
    // on accept so they keep their last value while no strobe is active.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wen_d    = mem_wen_q;
        mem_ren_d    = mem_ren_q;
        write_mf_d   = write_mf_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.REQ_VALID) begin
                    if (addr_oob) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (bus.REQ_WRITE) begin
                        state_d     = WR;
                        mem_addr_d  = bus.REQ_ADDR;
                        mem_wdata_d = bus.REQ_WDATA;
                        mem_wen_d   = 1'b1;
                        write_mf_d  = 1'b1;
                    end else begin
                        state_d    = RD;
                        mem_addr_d = bus.REQ_ADDR;
                        mem_ren_d  = 1'b1;
                    end
                end
            end
            RD: begin
                // The memory samples MEM_REN at this edge; data is on
                // MEM_RDATA during CAP.
                state_d   = CAP;
                mem_ren_d = 1'b0;
            end
            CAP: begin
                state_d      = RESP;
                resp_rdata_d = bus.MEM_RDATA;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
            end
            WR: begin
                state_d      = RESP;
                mem_wen_d    = 1'b0;
                write_mf_d   = 1'b0;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            RESP: begin
                if (bus.RESP_READY) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                mem_wen_d    = 1'b0;
                mem_ren_d    = 1'b0;
                write_mf_d   = 1'b0;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
            end
        endcase
    end

    // Reset clears every strobe asynchronously, so a store still waiting
    // in WR is never written and a pending response is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wen_q    <= 1'b0;
            mem_ren_q    <= 1'b0;
            write_mf_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wen_q    <= mem_wen_d;
            mem_ren_q    <= mem_ren_d;
            write_mf_q   <= write_mf_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    lsu_sat_counter #(
        .CNT_W (CNT_W)
    ) u_txn_count (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (resp_done),
        .count  (TXN_COUNT)
    );

    // REQ_READY is gated by rst_n so it is low for the whole reset period.
    assign bus.REQ_READY  = rst_n && (state_q == IDLE);
    assign bus.RESP_VALID = resp_valid_q;
    assign bus.RESP_ERR   = resp_err_q;
    assign bus.RESP_RDATA = resp_rdata_q;
    assign bus.MEM_ADDR   = mem_addr_q;
    assign bus.MEM_WDATA  = mem_wdata_q;
    assign bus.MEM_WEN    = mem_wen_q;
    assign bus.MEM_REN    = mem_ren_q;
    assign bus.WRITE_MF   = write_mf_q;

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu
// Self-checking bench for mem_lsu. Contains a word memory with 1-cycle
// registered reads attached to the memory port, and a transaction-level
// reference (expected memory contents, latency per request kind, saturating
// response count) against which every response is compared.
// -----------------------------------------------------------------------------
module tb_mem_lsu;
    import mem_pkg::*;

    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_lsu_if bus ();
    logic [TB_CNT_W-1:0] txn_count;

    mem_lsu #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .TXN_COUNT (txn_count)
    );

    // Memory attached to the LSU, plus a back door used only for preloading.
    logic [DATA_W-1:0] mem [DEPTH];
    logic              load_en   = 1'b0;
    logic [4:0]        load_addr = '0;
    logic [DATA_W-1:0] load_data = '0;

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (bus.MEM_WEN && bus.WRITE_MF) begin
            mem[bus.MEM_ADDR[4:0]] <= bus.MEM_WDATA;
        end
        if (bus.MEM_REN) begin
            bus.MEM_RDATA <= mem[bus.MEM_ADDR[4:0]];
        end
    end

    // Reference state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                ref_count = 0;

    int checks = 0;
    int passed = 0;

    task automatic apply_reset();
        rst_n          = 1'b0;
        bus.REQ_VALID  = 1'b0;
        bus.REQ_WRITE  = 1'b0;
        bus.REQ_ADDR   = '0;
        bus.REQ_WDATA  = '0;
        bus.RESP_READY = 1'b1;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        ref_count = 0;
        @(negedge clk);
    endtask

    task automatic preload_memory();
        for (int i = 0; i < DEPTH; i++) begin
            load_addr  = 5'(i);
            load_data  = (i == 8) ? 32'h0000_00FF : $urandom;
            ref_mem[i] = load_data;
            load_en    = 1'b1;
            @(negedge clk);
        end
        load_en = 1'b0;
    endtask

    // One complete transaction; hold > 0 keeps RESP_READY low for that many
    // cycles while a competing request is offered.
    task automatic run_req(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold,
                           input string tag);
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
        int                exp_lat;
        int                exp_count;
        int                exp_ren;
        int                exp_wen;
        int                lat;
        int                ren_cnt;
        int                wen_cnt;
        int                bus_bad;
        int                hold_bad;

        exp_err   = (addr >= 32'(DEPTH));
        exp_lat   = exp_err ? 1 : (wr ? 2 : 3);
        exp_rdata = (exp_err || wr) ? '0 : ref_mem[addr[4:0]];
        exp_ren   = (!exp_err && !wr) ? 1 : 0;
        exp_wen   = (!exp_err && wr) ? 1 : 0;
        if (!exp_err && wr) ref_mem[addr[4:0]] = wdata;
        exp_count = (ref_count < CNT_MAX) ? ref_count + 1 : CNT_MAX;
        ref_count = exp_count;

        bus.RESP_READY = (hold == 0);
        checks++;
        if (bus.REQ_READY !== 1'b1)
            $display("[TB] FAIL %s req_ready_before: got %b expected 1", tag, bus.REQ_READY);
        else passed++;

        bus.REQ_VALID = 1'b1;
        bus.REQ_WRITE = wr;
        bus.REQ_ADDR  = addr;
        bus.REQ_WDATA = wdata;
        @(posedge clk);
        @(negedge clk);
        // Scramble the request lines: only the accept edge may matter.
        bus.REQ_VALID = 1'b0;
        bus.REQ_WRITE = ~wr;
        bus.REQ_ADDR  = $urandom;
        bus.REQ_WDATA = $urandom;

        lat = 1; ren_cnt = 0; wen_cnt = 0; bus_bad = 0;
        while (bus.RESP_VALID !== 1'b1 && lat < 8) begin
            if (bus.MEM_REN === 1'b1) begin
                ren_cnt++;
                if (bus.MEM_ADDR !== addr) bus_bad++;
            end
            if (bus.MEM_WEN === 1'b1) begin
                wen_cnt++;
                if (bus.MEM_ADDR !== addr || bus.MEM_WDATA !== wdata) bus_bad++;
            end
            if (bus.WRITE_MF !== bus.MEM_WEN) bus_bad++;
            if (bus.MEM_REN === 1'b1 && bus.MEM_WEN === 1'b1) bus_bad++;
            @(negedge clk);
            lat++;
        end

        checks++;
        if (lat != exp_lat)
            $display("[TB] FAIL %s latency: got %0d edges expected %0d", tag, lat, exp_lat);
        else passed++;
        checks++;
        if (bus.RESP_ERR !== exp_err)
            $display("[TB] FAIL %s resp_err: got %b expected %b", tag, bus.RESP_ERR, exp_err);
        else passed++;
        checks++;
        if (bus.RESP_RDATA !== exp_rdata)
            $display("[TB] FAIL %s resp_rdata: got %h expected %h", tag, bus.RESP_RDATA, exp_rdata);
        else passed++;
        checks++;
        if (ren_cnt != exp_ren || wen_cnt != exp_wen)
            $display("[TB] FAIL %s strobe_cycles: got ren=%0d wen=%0d expected ren=%0d wen=%0d",
                     tag, ren_cnt, wen_cnt, exp_ren, exp_wen);
        else passed++;
        checks++;
        if (bus_bad != 0)
            $display("[TB] FAIL %s mem_bus: got %0d bad cycles expected 0", tag, bus_bad);
        else passed++;

        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            bus.REQ_VALID = 1'b1;
            bus.REQ_WRITE = 1'($urandom_range(0, 1));
            bus.REQ_ADDR  = 32'($urandom_range(0, DEPTH - 1));
            @(negedge clk);
            if (bus.RESP_VALID !== 1'b1 || bus.RESP_RDATA !== exp_rdata ||
                bus.RESP_ERR !== exp_err || bus.REQ_READY !== 1'b0 ||
                bus.MEM_REN !== 1'b0 || bus.MEM_WEN !== 1'b0)
                hold_bad++;
        end
        if (hold > 0) begin
            checks++;
            if (hold_bad != 0)
                $display("[TB] FAIL %s backpressure_hold: got %0d unstable cycles expected 0", tag, hold_bad);
            else passed++;
        end

        bus.RESP_READY = 1'b1;
        @(negedge clk);
        bus.REQ_VALID = 1'b0;

        checks++;
        if (bus.RESP_VALID !== 1'b0 || bus.RESP_ERR !== 1'b0)
            $display("[TB] FAIL %s release: got valid=%b err=%b expected 0 0", tag, bus.RESP_VALID, bus.RESP_ERR);
        else passed++;
        checks++;
        if (txn_count !== TB_CNT_W'(exp_count))
            $display("[TB] FAIL %s txn_count: got %0d expected %0d", tag, txn_count, exp_count);
        else passed++;
        checks++;
        if (bus.REQ_READY !== 1'b1 || bus.MEM_REN !== 1'b0 || bus.MEM_WEN !== 1'b0)
            $display("[TB] FAIL %s idle_after: got ready=%b ren=%b wen=%b expected 1 0 0",
                     tag, bus.REQ_READY, bus.MEM_REN, bus.MEM_WEN);
        else passed++;
    endtask

    task automatic check_memory(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        checks++;
        if (bad != 0)
            $display("[TB] FAIL %s memory_contents: got %0d differing words expected 0", tag, bad);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.REQ_READY !== 1'b0 || bus.RESP_VALID !== 1'b0 || bus.RESP_ERR !== 1'b0 ||
            bus.MEM_WEN !== 1'b0 || bus.MEM_REN !== 1'b0 || bus.WRITE_MF !== 1'b0)
            $display("[TB] FAIL reset_flags: got ready=%b valid=%b err=%b wen=%b ren=%b mf=%b expected all 0",
                     bus.REQ_READY, bus.RESP_VALID, bus.RESP_ERR, bus.MEM_WEN, bus.MEM_REN, bus.WRITE_MF);
        else passed++;
        checks++;
        if (bus.RESP_RDATA !== '0 || bus.MEM_ADDR !== '0 || bus.MEM_WDATA !== '0 || txn_count !== '0)
            $display("[TB] FAIL reset_values: got rdata=%h addr=%h wdata=%h count=%0d expected all 0",
                     bus.RESP_RDATA, bus.MEM_ADDR, bus.MEM_WDATA, txn_count);
        else passed++;
        @(negedge clk);
        rst_n     = 1'b1;
        ref_count = 0;
        #1;
        checks++;
        if (bus.REQ_READY !== 1'b1)
            $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.REQ_READY);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        run_req(1'b0, 32'd8, 32'h0, 0, "load_addr8");
    endtask

    task automatic test_store_load();
        run_req(1'b1, 32'd20, 32'hDEAD_BEEF, 0, "store_addr20");
        run_req(1'b0, 32'd20, 32'h0, 0, "load_addr20");
    endtask

    task automatic test_bounds();
        run_req(1'b0, 32'd31, 32'h0, 0, "load_addr31");
        run_req(1'b0, 32'd32, 32'h0, 0, "load_addr32");
        run_req(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 0, "store_addr_max");
        check_memory("bounds");
    endtask

    task automatic test_backpressure();
        run_req(1'b0, 32'd3, 32'h0, 5, "load_backpressure");
        run_req(1'b1, 32'd5, $urandom, 0, "store_after_release");
    endtask

    task automatic test_reset_mid_write();
        logic [DATA_W-1:0] old_word;
        old_word       = ref_mem[20];
        bus.RESP_READY = 1'b1;
        bus.REQ_VALID  = 1'b1;
        bus.REQ_WRITE  = 1'b1;
        bus.REQ_ADDR   = 32'd20;
        bus.REQ_WDATA  = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        checks++;
        if (bus.MEM_WEN !== 1'b1)
            $display("[TB] FAIL midwrite_in_wr: got wen=%b expected 1", bus.MEM_WEN);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.MEM_WEN !== 1'b0 || bus.WRITE_MF !== 1'b0 || bus.RESP_VALID !== 1'b0 || txn_count !== '0)
            $display("[TB] FAIL midwrite_reset: got wen=%b mf=%b valid=%b count=%0d expected 0 0 0 0",
                     bus.MEM_WEN, bus.WRITE_MF, bus.RESP_VALID, txn_count);
        else passed++;
        @(negedge clk);
        rst_n     = 1'b1;
        ref_count = 0;
        @(negedge clk);
        checks++;
        if (mem[20] !== old_word || bus.REQ_READY !== 1'b1)
            $display("[TB] FAIL midwrite_word: got word=%h ready=%b expected %h 1", mem[20], bus.REQ_READY, old_word);
        else passed++;
        run_req(1'b0, 32'd20, 32'h0, 0, "load_after_reset");
    endtask

    task automatic test_back_to_back();
        int exp_tbl [5] = '{1, 2, 3, 3, 3};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, 32'($urandom_range(0, DEPTH - 1)), 32'h0, 0, "b2b_load");
            checks++;
            if (txn_count !== TB_CNT_W'(exp_tbl[i]))
                $display("[TB] FAIL b2b_count_%0d: got %0d expected %0d", i, txn_count, exp_tbl[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int          sel;
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
            else if (sel == 1) addr = 32'(DEPTH) + 32'($urandom_range(0, 3));
            else               addr = 32'($urandom_range(0, DEPTH - 1));
            run_req(1'($urandom_range(0, 1)), addr, $urandom, 0, "random");
        end
        check_memory("random");
    endtask

    initial begin
        apply_reset();
        preload_memory();
        test_basic_load();
        test_reset();
        test_store_load();
        test_bounds();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
